// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_reg
//  Purpose  : Pipeline stage register with a valid/ready handshake, a
//             synchronous flush and a one-entry skid buffer. Outputs come
//             straight from flops and in_ready depends only on held state
//             (and rst), so there is no combinational path from out_ready
//             to in_ready. Throughput is one beat per cycle.
//  Ports    :
//    clk        in   clock, rising edge
//    rst        in   synchronous reset, active low
//    flush      in   synchronous squash of all held entries
//    in_valid   in   upstream has data
//    in_ready   out  stage can accept data this cycle
//    in_data    in   upstream payload [WIDTH-1:0]
//    out_valid  out  out_data holds a valid entry
//    out_ready  in   downstream consumes this cycle
//    out_data   out  oldest held payload [WIDTH-1:0]
//    occupancy  out  number of held entries (0..2)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Storage. The pair {r_main_vld, r_skid_vld} doubles as the state:
    // 00 EMPTY, 10 ONE, 11 FULL. 01 cannot be reached because the skid is
    // only filled while main is valid and is always drained into main.
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_main_vld;
    logic             r_skid_vld;

    logic             w_accept;
    logic             w_pop;

    // Readiness is purely a function of the skid flop, which keeps the
    // upstream ready path free of any downstream logic. rst gates it so no
    // beat is considered accepted during a reset edge.
    assign in_ready  = rst & ~r_skid_vld;
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = r_main_vld & out_ready;

    assign out_valid = r_main_vld;
    assign out_data  = r_main_data;
    assign occupancy = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_vld  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_main_data <= RESET_VAL;
            r_skid_data <= RESET_VAL;
        end else if (flush) begin
            // Squash only the valid bits; payload flops keep their contents.
            // Any handshake completing this cycle is discarded.
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_main_vld) begin
            // EMPTY: a new beat goes straight into main.
            if (w_accept) begin
                r_main_data <= in_data;
                r_main_vld  <= 1'b1;
            end
        end else if (!r_skid_vld) begin
            // ONE
            if (w_accept && w_pop) begin
                r_main_data <= in_data;
            end else if (w_accept) begin
                // Downstream stalled: park the in-flight beat in the skid.
                r_skid_data <= in_data;
                r_skid_vld  <= 1'b1;
            end else if (w_pop) begin
                r_main_vld <= 1'b0;
            end
        end else begin
            // FULL: in_ready is low, so only a pop can change state.
            if (w_pop) begin
                r_main_data <= r_skid_data;
                r_skid_vld  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_skid_reg
//  Purpose  : Bench for pipe_skid_reg. Stimulus and a FIFO reference model
//             run on the rising edge; a monitor on the falling edge compares
//             the DUT outputs against the expected-entry queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int unsigned      WIDTH     = 32;
    localparam logic [WIDTH-1:0] RESET_VAL = 32'h1234_5678;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: entries held by the stage, oldest first (max 2).
    logic [WIDTH-1:0] exp_q[$];
    // Set when the payload register still holds the reset value.
    bit               exp_rstdata = 1'b0;
    // Whether the stage may accept this cycle, decided before any pop.
    bit               exp_ready   = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare held state, then consume the head on a downstream pop.
    always @(negedge clk) begin
        exp_ready = rst && (exp_q.size() < 2);
        check("in_ready",  {31'b0, in_ready},  {31'b0, exp_ready});
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
        check("occupancy", {30'b0, occupancy}, 32'(exp_q.size()));
        if (exp_q.size() > 0) begin
            check("out_data", out_data, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
        end else if (exp_rstdata) begin
            check("reset_data", out_data, RESET_VAL);
        end
    end

    // Reference update on the active edge: reset, then flush, then accept.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            exp_rstdata = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else if (in_valid && exp_ready) begin
            exp_q.push_back(in_data);
            exp_rstdata = 1'b0;
        end
    end

    // Apply one cycle of inputs, then move just past the next rising edge.
    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [WIDTH-1:0] d, input bit ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for three cycles with a beat presented upstream.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Streaming at full rate.
        step(1'b1, 1'b0, 1'b1, 32'h1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure into the skid, then drain with C re-presented.
        step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush while FULL with a beat offered.
        step(1'b1, 1'b0, 1'b1, 32'h21, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h23, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush coinciding with an accept while EMPTY.
        step(1'b1, 1'b1, 1'b1, 32'h55, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset and flush together while ONE.
        step(1'b1, 1'b0, 1'b1, 32'h77, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h78, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        // Drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register for the myCPU datapath, replacing the bare enable/reset flop between pipeline stages. It carries a WIDTH-bit payload with a valid/ready handshake, a synchronous flush for branch/exception squash, and a one-entry skid buffer. The skid buffer gives full throughput with fully registered outputs, so no combinational path runs from downstream ready to upstream ready. It sits between any two pipeline stages (e.g. IF/ID, ID/EX) and between the CPU and the SRAM-interface request path.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- RESET_VAL, 0, value loaded into both data registers on reset (WIDTH bits)

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets the block)
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream has data
- in_ready  output  1  block can accept data this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream consumes this cycle
- out_data  output  WIDTH  oldest held payload
- occupancy  output  2  number of valid entries held (0, 1 or 2)

## Operation
- Storage: main register (drives out_data, main_vld), skid register (skid_data, skid_vld).
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = rst & ~skid_vld. It is a function of registered state and rst only.
- out_valid = main_vld; out_data = main_data; occupancy = main_vld + skid_vld.
- States (encoded by main_vld/skid_vld):
  - EMPTY (0/0)
  - ONE (1/0)
  - FULL (1/1)
  - 0/1 is illegal and never reached.
- Transitions (flush=0, rst=1):
  - EMPTY: accept → ONE, main_data<=in_data. Otherwise stay.
  - ONE:
    - accept & pop → ONE, main_data<=in_data.
    - accept & ~pop → FULL, skid_data<=in_data.
    - ~accept & pop → EMPTY.
    - Neither → stay; main_data unchanged.
  - FULL: accept is impossible because in_ready=0.
    - pop → ONE, main_data<=skid_data, skid_vld<=0.
    - ~pop → stay.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush or reset.
- Flush (rst=1, flush=1): next state EMPTY regardless of accept/pop.
  - A handshake completing in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed by downstream.
  - Data registers hold their values and are not cleared.
- Reset has priority over flush and handshakes. At a rising edge with rst==0:
  - main_vld=skid_vld=0.
  - main_data=skid_data=RESET_VAL.

## Timing
- Reset values: out_valid=0, out_data=RESET_VAL, occupancy=0.
- in_ready=0 while rst==0, and 1 in the first cycle after reset release.
- Latency: data accepted at edge N (EMPTY) appears on out_data with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- Backpressure: with out_ready low for one edge while streaming, in_ready drops 1 cycle later. This is because the skid absorbs the in-flight beat.
- Stability: while out_valid & ~out_ready, out_data and out_valid hold unchanged on the next edge (absent flush/reset).
- Simultaneous flush + reset: reset wins, with the same outcome (EMPTY) and data = RESET_VAL.
- Reset mid-transfer: all held entries are lost. The upstream beat presented during the reset edge is not accepted (in_ready=0).

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1, in_data=0xDEADBEEF, RESET_VAL=0x12345678 → out_valid=0, out_data=0x12345678, occupancy=0, in_ready=0. After release, in_ready=1.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 on the following three cycles with out_valid=1. in_ready stays 1 and occupancy stays 1.
- Backpressure/skid: push 0xA,0xB,0xC with out_ready=0 from the second cycle → 0xA held on out, 0xB in skid, occupancy=2, in_ready=0, 0xC not accepted. Raise out_ready → outputs 0xA, 0xB, then 0xC once re-presented; no loss, no duplicates.
- Flush in FULL: occupancy=2, assert flush with in_valid=1 → next cycle out_valid=0, occupancy=0, in_ready=1; the flushed entries never appear on out.
- Flush with simultaneous accept in EMPTY: in_valid=1, in_data=0x55, flush=1 → next cycle out_valid=0 and 0x55 never emitted.
- Reset vs flush priority: assert flush=1 and rst=0 together in state ONE → next cycle EMPTY, out_data=RESET_VAL.
